// File: rtl/gs232c_btb_bitmap_ctrl_pkg.sv
// Shared types and constants for the BTB bitmap controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, update-queue entry struct, bitmap geometry constants.
package gs232c_btb_bitmap_ctrl_pkg;

    localparam int         BM_ADDR_W  = 10;
    localparam int         BM_DATA_W  = 4;
    localparam logic [7:0] SWEEP_LAST = 8'd255;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic [BM_ADDR_W-1:0] addr;
        logic [BM_DATA_W-1:0] mask;
        logic [BM_DATA_W-1:0] data;
    } upd_entry_t;

endpackage

// File: rtl/gs232c_btb_upd_fifo.sv
// In-order update queue holding {addr,mask,data} entries.
// Latency: a pushed entry is visible at o_head_dat the cycle after the push.
// Backpressure: o_full blocks pushes; pop on empty is ignored; i_flush empties it.
//
// Ports: clock/reset, i_push/i_push_dat, i_pop, i_flush, o_head_dat, o_full, o_empty.
module gs232c_btb_upd_fifo
    import gs232c_btb_bitmap_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_push,
    input  upd_entry_t i_push_dat,
    input  logic       i_pop,
    input  logic       i_flush,
    output upd_entry_t o_head_dat,
    output logic       o_full,
    output logic       o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    upd_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;

    always_ff @(posedge clock) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gs232c_btb_bitmap_ctrl.sv
// BTB bitmap controller: clear sweep, queued masked updates, registered reads.
// Latency: update written the cycle after acceptance (unless deferred); read data 1 cycle.
// Backpressure: upd_ready low while sweeping or queue full; row-conflicting reads
//               defer the head write up to STARVE_MAX cycles.
//
// Ports: clock/reset, flush_req/busy, upd_* request channel, rd_* read channel,
//        bm_* bitmap array interface. Optional macro GS232C_BTB_BITMAP_CTRL_PERF_EN
//        adds perf_defer/perf_flush saturating event counters.
module gs232c_btb_bitmap_ctrl
    import gs232c_btb_bitmap_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush_req,
    output logic                 busy,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [BM_ADDR_W-1:0] upd_addr,
    input  logic [BM_DATA_W-1:0] upd_mask,
    input  logic [BM_DATA_W-1:0] upd_data,
    input  logic                 rd_en,
    input  logic [BM_ADDR_W-1:0] rd_addr,
    output logic                 rd_valid,
    output logic [BM_DATA_W-1:0] rd_data,
    output logic [BM_ADDR_W-1:0] bm_raddr,
    input  logic [BM_DATA_W-1:0] bm_rdata,
    output logic [BM_ADDR_W-1:0] bm_waddr,
    output logic [BM_DATA_W-1:0] bm_wmask,
    output logic [BM_DATA_W-1:0] bm_wdata
`ifdef GS232C_BTB_BITMAP_CTRL_PERF_EN
    ,
    output logic [15:0]          perf_defer,
    output logic [15:0]          perf_flush
`endif
);

    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    state_e               r_state;
    logic [7:0]           r_cnt;
    logic                 r_busy;
    logic [STV_W-1:0]     r_starve;
    logic                 r_rd_valid;
    logic [BM_DATA_W-1:0] r_rd_data;

    upd_entry_t           w_head;
    upd_entry_t           w_push_dat;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_run;
    logic                 w_push;
    logic                 w_have;
    logic                 w_conflict;
    logic                 w_defer;
    logic                 w_wr;
    logic                 w_rd_take;

    assign w_run      = (r_state == RUN);
    assign upd_ready  = w_run && !w_full;
    assign w_push     = upd_valid && upd_ready;
    assign w_push_dat = '{addr: upd_addr, mask: upd_mask, data: upd_data};

    // A flush in RUN drops the head in the same cycle, so it never reaches the array.
    assign w_have     = w_run && !w_empty && !flush_req;
    // Same 16-bit row as the head write: give the read the array, but only
    // STARVE_MAX times in a row so the queue cannot stall forever.
    assign w_conflict = rd_en && (rd_addr[BM_ADDR_W-1:4] == w_head.addr[BM_ADDR_W-1:4]);
    assign w_defer    = w_have && w_conflict && (r_starve != STV_W'(STARVE_MAX));
    assign w_wr       = w_have && !w_defer;
    assign w_rd_take  = rd_en && w_run;

    gs232c_btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_upd_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_wr),
        .i_flush    (flush_req),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign busy     = r_busy;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign bm_raddr = rd_addr;

    always_comb begin
        bm_waddr = w_head.addr;
        bm_wmask = '0;
        bm_wdata = w_head.data;
        if (!w_run) begin
            bm_waddr = {r_cnt, 2'b00};
            bm_wmask = '1;
            bm_wdata = '0;
        end else if (w_wr) begin
            bm_wmask = w_head.mask;
        end
    end

    // Controller FSM; busy is registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (flush_req) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == SWEEP_LAST) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (flush_req || w_wr) begin
            r_starve <= '0;
        end else if (w_defer) begin
            r_starve <= r_starve + STV_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_take;
            r_rd_data  <= w_rd_take ? bm_rdata : '0;
        end
    end

`ifdef GS232C_BTB_BITMAP_CTRL_PERF_EN
    logic [15:0] r_perf_defer;
    logic [15:0] r_perf_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_defer <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_defer && (r_perf_defer != 16'hffff))   r_perf_defer <= r_perf_defer + 16'd1;
            if (flush_req && (r_perf_flush != 16'hffff)) r_perf_flush <= r_perf_flush + 16'd1;
        end
    end

    assign perf_defer = r_perf_defer;
    assign perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_gs232c_btb_bitmap_ctrl.sv
// Directed bench for gs232c_btb_bitmap_ctrl with a nibble-wide bitmap array model.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after it.
module tb_gs232c_btb_bitmap_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flush_req = 1'b0;
    logic       busy;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic [9:0] upd_addr = '0;
    logic [3:0] upd_mask = '0;
    logic [3:0] upd_data = '0;
    logic       rd_en = 1'b0;
    logic [9:0] rd_addr = '0;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [9:0] bm_raddr;
    logic [3:0] bm_rdata;
    logic [9:0] bm_waddr;
    logic [3:0] bm_wmask;
    logic [3:0] bm_wdata;
`ifdef GS232C_BTB_BITMAP_CTRL_PERF_EN
    logic [15:0] perf_defer;
    logic [15:0] perf_flush;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Bitmap array: 256 nibble words, a 4-bit group per aligned address.
    logic [3:0] mem [256];
    assign bm_rdata = mem[bm_raddr[9:2]];
    always @(posedge clock) begin
        if (bm_wmask != 4'h0)
            mem[bm_waddr[9:2]] <= (mem[bm_waddr[9:2]] & ~bm_wmask) | (bm_wdata & bm_wmask);
    end

    always #5 clock = ~clock;

    gs232c_btb_bitmap_ctrl #(
        .FIFO_DEPTH (2),
        .STARVE_MAX (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush_req (flush_req),
        .busy      (busy),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_addr  (upd_addr),
        .upd_mask  (upd_mask),
        .upd_data  (upd_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .bm_raddr  (bm_raddr),
        .bm_rdata  (bm_rdata),
        .bm_waddr  (bm_waddr),
        .bm_wmask  (bm_wmask),
        .bm_wdata  (bm_wdata)
`ifdef GS232C_BTB_BITMAP_CTRL_PERF_EN
        ,
        .perf_defer (perf_defer),
        .perf_flush (perf_flush)
`endif
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_upd(input logic v, input logic [9:0] a, input logic [3:0] m, input logic [3:0] d);
        upd_valid = v;
        upd_addr  = a;
        upd_mask  = m;
        upd_data  = d;
    endtask

    // Counts busy cycles from the current one; gives up after 300.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            if (busy !== 1'b1) break;
            n++;
            tick();
        end
    endtask

    initial begin
        int         n;
        logic [9:0] ea;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clock);
        #1;
        settle();
        chk("rst_busy", busy, 1);
        chk("rst_upd_ready", upd_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);

        // ---------------- reset release sweep ----------------
        reset = 1'b0;
        settle();
        for (int i = 0; i < 256; i++) begin
            ea = 10'(i * 4);
            chk("sweep", {busy, bm_waddr, bm_wmask, bm_wdata}, {1'b1, ea, 4'hf, 4'h0});
            tick();
        end
        settle();
        chk("sweep_done_busy", busy, 0);
        chk("sweep_done_ready", upd_ready, 1);
        chk("idle_wmask", bm_wmask, 0);

        // ---------------- update then read ----------------
        set_upd(1, 10'h005, 4'hf, 4'ha);
        settle();
        chk("upd_ready", upd_ready, 1);
        tick();
        set_upd(0, 10'h000, 4'h0, 4'h0);
        settle();
        chk("upd_write", {bm_waddr, bm_wmask, bm_wdata}, {10'h005, 4'hf, 4'ha});
        tick();
        rd_en = 1'b1; rd_addr = 10'h005;
        settle();
        chk("raddr_comb", bm_raddr, 10'h005);
        chk("empty_wmask", bm_wmask, 0);
        tick();
        rd_en = 1'b0;
        settle();
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, 4'ha);
        tick();
        settle();
        chk("rd_valid_drop", rd_valid, 0);

        // ---------------- row conflict ----------------
        rd_en = 1'b1; rd_addr = 10'h043;
        set_upd(1, 10'h040, 4'h3, 4'h1);
        settle();
        chk("rc_ready0", upd_ready, 1);
        tick();
        set_upd(1, 10'h200, 4'hf, 4'h5);
        settle();
        chk("rc_defer1", bm_wmask, 0);
        chk("rc_ready1", upd_ready, 1);
        chk("rc_rd_valid", rd_valid, 1);
        tick();
        set_upd(1, 10'h300, 4'hf, 4'h6);
        settle();
        chk("rc_full", upd_ready, 0);
        chk("rc_defer2", bm_wmask, 0);
        chk("rc_rd_old", rd_data, 0);
        tick();
        settle();
        chk("rc_issue", {bm_waddr, bm_wmask, bm_wdata}, {10'h040, 4'h3, 4'h1});
        chk("rc_full_pop", upd_ready, 0);
        tick();
        settle();
        chk("rc_ready_again", upd_ready, 1);
        chk("rc_second", {bm_waddr, bm_wmask, bm_wdata}, {10'h200, 4'hf, 4'h5});
        chk("rc_read_wins", rd_data, 0);
        tick();
        set_upd(0, 10'h000, 4'h0, 4'h0);
        rd_en = 1'b0;
        settle();
        chk("rc_third", {bm_waddr, bm_wmask, bm_wdata}, {10'h300, 4'hf, 4'h6});
        chk("rc_rd_new", rd_data, 4'h1);
        tick();
        settle();
        chk("rc_drained", bm_wmask, 0);

        // ---------------- flush in RUN ----------------
        rd_en = 1'b1; rd_addr = 10'h080;
        set_upd(1, 10'h080, 4'hf, 4'h7);
        tick();
        set_upd(1, 10'h084, 4'hf, 4'h9);
        settle();
        chk("fl_defer1", bm_wmask, 0);
        tick();
        set_upd(0, 10'h000, 4'h0, 4'h0);
        settle();
        chk("fl_full", upd_ready, 0);
        tick();
        flush_req = 1'b1;
        settle();
        chk("fl_no_write", bm_wmask, 0);
        tick();
        flush_req = 1'b0;
        rd_en = 1'b1; rd_addr = 10'h080;
        settle();
        chk("fl_clear", {busy, bm_waddr}, {1'b1, 10'h000});
        tick();
        rd_en = 1'b0;
        settle();
        chk("fl_rd_in_clear", {rd_valid, rd_data}, {1'b0, 4'h0});
        count_busy(n);
        n = n + 1;
        chk("fl_busy_len", n, 256);
        settle();
        chk("fl_discarded", bm_wmask, 0);
        chk("fl_ready", upd_ready, 1);

        // ---------------- flush mid-sweep ----------------
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (100) tick();
        settle();
        chk("ms_cnt100", bm_waddr, 10'd400);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        settle();
        chk("ms_restart", bm_waddr, 10'h000);
        count_busy(n);
        chk("ms_busy_len", n, 256);

`ifdef GS232C_BTB_BITMAP_CTRL_PERF_EN
        // ---------------- perf counters ----------------
        reset = 1'b1;
        tick();
        settle();
        chk("pf_rst_defer", perf_defer, 0);
        chk("pf_rst_flush", perf_flush, 0);
        reset = 1'b0;
        repeat (256) tick();
        settle();
        chk("pf_run", busy, 0);
        rd_en = 1'b1; rd_addr = 10'h100;
        set_upd(1, 10'h100, 4'hf, 4'h2);
        tick();
        set_upd(0, 10'h000, 4'h0, 4'h0);
        repeat (3) tick();
        set_upd(1, 10'h104, 4'hf, 4'h3);
        tick();
        set_upd(0, 10'h000, 4'h0, 4'h0);
        tick();
        rd_en = 1'b0;
        tick();
        settle();
        chk("pf_defer3", perf_defer, 16'd3);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        settle();
        chk("pf_flush2", perf_flush, 16'd2);
        chk("pf_defer_hold", perf_defer, 16'd3);
        flush_req = 1'b1;
        repeat (65540) tick();
        flush_req = 1'b0;
        settle();
        chk("pf_sat", perf_flush, 16'hffff);
        tick();
        settle();
        chk("pf_sat_hold", perf_flush, 16'hffff);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gs232c_btb_bitmap_ctrl.md
GS232C_BTB_BITMAP_CTRL -- requirements
Module: gs232c_btb_bitmap_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning update-queue entries.
REQ-002 SHALL have parameter STARVE_MAX, default 2, meaning the maximum consecutive deferrals of the queue-head write.
REQ-003 Ports (name  direction  width  meaning):
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush_req  in  1  pulse; re-clear the whole bitmap.
- busy  out  1  clear sweep in progress.
- upd_valid  in  1  update request.
- upd_ready  out  1  update accepted when valid&&ready.
- upd_addr  in  10  update bit address.
- upd_mask  in  4  update bit mask.
- upd_data  in  4  update bit data.
- rd_en  in  1  read request.
- rd_addr  in  10  read bit address.
- rd_valid  out  1  rd_data valid.
- rd_data  out  4  registered read data.
- bm_raddr  out  10  bitmap read address.
- bm_rdata  in  4  bitmap combinational read data.
- bm_waddr  out  10  bitmap write address.
- bm_wmask  out  4  bitmap write mask.
- bm_wdata  out  4  bitmap write data.

Function
REQ-004 State machine SHALL have two states, CLEAR and RUN.
- reset or flush_req -> CLEAR.
- CLEAR with sweep count 255 -> RUN.
REQ-005 In CLEAR, the block SHALL drive bm_waddr={cnt[7:0],2'b00}, bm_wmask=4'hf and bm_wdata=4'h0, incrementing cnt every cycle (256 cycles total).
REQ-006 flush_req in CLEAR SHALL restart cnt at 0; flush_req in RUN SHALL discard all queued updates in the same cycle.
REQ-007 busy SHALL be 1 exactly while in CLEAR.
REQ-008 upd_ready SHALL be 1 only in RUN with the queue not full; a push and a pop in the same cycle SHALL be allowed only when the queue is not full.
REQ-009 The update queue SHALL be in-order, holding {addr,mask,data}.
REQ-010 In RUN with the queue non-empty, the block SHALL write the head to bm_* and pop it that cycle, unless deferred per REQ-011.
REQ-011 Row-conflict deferral:
- the head write SHALL be deferred (bm_wmask=0) when rd_en && rd_addr[9:4]==head.addr[9:4];
- after STARVE_MAX consecutive deferrals the write SHALL proceed regardless of rd_en;
- the deferral counter SHALL clear on every pop.
REQ-012 bm_wmask SHALL be 4'h0 in any cycle with no write.
REQ-013 bm_raddr SHALL equal rd_addr combinationally.
REQ-014 Read timing:
- rd_valid SHALL be 1 one cycle after rd_en sampled in RUN, with rd_data=bm_rdata registered from that cycle;
- rd_en in CLEAR SHALL give rd_valid=0 and rd_data=4'h0 the following cycle.
REQ-015 A read that wins against a deferred write SHALL return pre-update data; ordering between that read and that write is not guaranteed.

Reset
REQ-016 Asynchronous reset SHALL force:
- state=CLEAR, cnt=0;
- queue empty, deferral counter 0;
- rd_valid=0, rd_data=0;
- upd_ready=0, busy=1.
REQ-017 Deassertion of reset SHALL start the sweep on the first clock edge; an assertion mid-sweep or mid-RUN SHALL abandon all state.

Configuration
REQ-018 With macro GS232C_BTB_BITMAP_CTRL_PERF_EN defined, the block SHALL add:
- output perf_defer [15:0], counting deferred cycles;
- output perf_flush [15:0], counting flush_req pulses.
Both SHALL saturate at 16'hffff and reset to 0.
REQ-019 Without GS232C_BTB_BITMAP_CTRL_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-020 A shared package SHALL hold:
- the state enum (CLEAR/RUN);
- the update-entry struct {addr[9:0],mask[3:0],data[3:0]};
- constants BM_ADDR_W=10, BM_DATA_W=4, SWEEP_LAST=255.
REQ-021 The update queue SHALL be one sub-module, gs232c_btb_upd_fifo (FIFO_DEPTH entries, push/pop/flush, full/empty); everything else SHALL be in the top module.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset release: busy=1 for exactly 256 cycles; bm_waddr walks 0,4,...,1020 with bm_wmask=f and bm_wdata=0; then busy=0 and upd_ready=1.
- Update and read: push addr=0x005, mask=4'hf, data=4'ha with no reads -> bm_waddr=0x005, bm_wmask=f, bm_wdata=a in the cycle after acceptance; rd_en with rd_addr=0x005 two cycles later -> rd_valid=1, rd_data=the model value 4'ha.
- Row conflict: head addr=0x040 with rd_en held and rd_addr=0x043 -> write deferred 2 cycles, issued in the 3rd; a 2nd update is accepted and the 3rd sees upd_ready=0 while full.
- Flush in RUN: flush_req with 2 queued updates -> neither is written; a 256-cycle sweep follows; rd_en during the sweep -> rd_valid=0.
- Flush mid-sweep: flush_req at cnt=100 -> next bm_waddr=0; busy lasts 256 more cycles.
- PERF_EN build: 3 deferrals and 2 flushes -> perf_defer=3 and perf_flush=2; a forced-overflow run holds 16'hffff.
